kb_event_sched: RTL and testbench



---
 rtl/kb_event_sched_if.sv | 30 +++
 rtl/kb_event_sched.sv | 177 +++++++++++++++++
 tb/tb_kb_event_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kb_event_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : kb_event_sched_if
// Description : CPU-side bus of the keyboard event scheduler: pop strobe,
//               control bits, head entry, FIFO status and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
interface kb_event_sched_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  rd_en;
    logic                  irq_en;
    logic                  clr_ovf;
    logic [15:0]           rd_data;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  irq;

    modport master (
        output rd_en, irq_en, clr_ovf,
        input  rd_data, empty, count, overflow, irq
    );

    modport slave (
        input  rd_en, irq_en, clr_ovf,
        output rd_data, empty, count, overflow, irq
    );
endinterface
`default_nettype wire

// File: rtl/kb_event_sched.sv
`default_nettype none
// ============================================================================
// Module      : kb_event_sched
// Description : Turns level-type keyboard state into press/auto-repeat events
//               queued in a show-ahead FIFO popped by the CPU; raises a level
//               interrupt while events are pending. Auto-repeat is built only
//               when KB_SCHED_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module kb_event_sched #(
    parameter int DELAY      = 25000000,
    parameter int PERIOD     = 5000000,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic        CLOCK_50,
    input  wire logic        rst,
    input  wire logic [7:0]  ascii,
    input  wire logic [4:0]  mods,
    kb_event_sched_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DELAY = 2'd1;

    localparam int                  c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_key;
    logic [7:0]  w_key_nxt;
    logic        w_push;
    logic        w_rep;

`ifdef KB_SCHED_REPEAT_EN
    localparam logic [1:0] c_ST_REPEAT = 2'd2;
    localparam int c_TMAX = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam logic [c_TW-1:0] c_DELAY_END  = c_TW'(DELAY - 1);
    localparam logic [c_TW-1:0] c_PERIOD_END = c_TW'(PERIOD - 1);

    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
`else
    logic w_unused_params;
    assign w_unused_params = ^{DELAY, PERIOD};
`endif

    // Event decode: release beats everything, a new key beats the timers.
    always_comb begin
        w_push      = 1'b0;
        w_rep       = 1'b0;
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
`ifdef KB_SCHED_REPEAT_EN
        w_timer_nxt = r_timer;
`endif
        if (ascii == 8'h00) begin
            w_state_nxt = c_ST_IDLE;
            w_key_nxt   = 8'h00;
`ifdef KB_SCHED_REPEAT_EN
            w_timer_nxt = '0;
`endif
        end else if (ascii != r_key) begin
            w_push      = 1'b1;
            w_key_nxt   = ascii;
            w_state_nxt = c_ST_DELAY;
`ifdef KB_SCHED_REPEAT_EN
            w_timer_nxt = '0;
`endif
        end else begin
`ifdef KB_SCHED_REPEAT_EN
            case (r_state)
                c_ST_DELAY: begin
                    if (r_timer == c_DELAY_END) begin
                        w_push      = 1'b1;
                        w_rep       = 1'b1;
                        w_state_nxt = c_ST_REPEAT;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + c_TW'(1);
                    end
                end
                c_ST_REPEAT: begin
                    if (r_timer == c_PERIOD_END) begin
                        w_push      = 1'b1;
                        w_rep       = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + c_TW'(1);
                    end
                end
                default: begin
                    w_timer_nxt = '0;
                end
            endcase
`endif
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_key   <= 8'h00;
`ifdef KB_SCHED_REPEAT_EN
            r_timer <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
`ifdef KB_SCHED_REPEAT_EN
            r_timer <= w_timer_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO; pointers carry one extra bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [15:0]          r_mem [c_DEPTH];
    logic [DEPTH_LOG2:0]  r_wr_ptr;
    logic [DEPTH_LOG2:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]  w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_drop;
    logic [15:0]          w_entry;
    logic                 r_overflow;
    logic                 r_irq;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_FULL);
    assign w_pop   = bus.rd_en & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_entry = {2'b00, w_rep, mods, ascii};

    always_ff @(posedge CLOCK_50) begin
        if (w_wr && !rst) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
            r_irq <= bus.irq_en & ~w_empty;
        end
    end

    assign bus.rd_data  = w_empty ? 16'h0000 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign bus.empty    = w_empty;
    assign bus.count    = w_count;
    assign bus.overflow = r_overflow;
    assign bus.irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_kb_event_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_kb_event_sched
// Description : Directed bench for kb_event_sched with an event/queue model
//               checked every cycle plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kb_event_sched;

    localparam int c_DELAY  = 10;
    localparam int c_PERIOD = 4;
    localparam int c_DLOG2  = 2;
    localparam int c_DEPTH  = 1 << c_DLOG2;

    logic       CLOCK_50 = 1'b0;
    logic       rst;
    logic [7:0] ascii;
    logic [4:0] mods;

    int n_checks = 0;
    int n_errors = 0;

    kb_event_sched_if #(.DEPTH_LOG2(c_DLOG2)) bus ();

    kb_event_sched #(
        .DELAY      (c_DELAY),
        .PERIOD     (c_PERIOD),
        .DEPTH_LOG2 (c_DLOG2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .ascii    (ascii),
        .mods     (mods),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: an event is a new key, or a held key whose age since its press
    // equals DELAY or DELAY plus a whole number of PERIODs.
    logic [15:0] m_q[$];
    logic        m_ovf   = 1'b0;
    logic        m_irq   = 1'b0;
    logic        m_live  = 1'b0;
    logic [7:0]  m_prev  = 8'h00;
    int          m_cyc   = 0;
    int          m_press = 0;

    always @(posedge CLOCK_50) begin
        logic        ev;
        logic        rep;
        logic        pop;
        logic        irq_nxt;
        int          age;
        m_cyc++;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_irq  = 1'b0;
            m_prev = 8'h00;
            m_live = 1'b1;
        end else begin
            ev  = 1'b0;
            rep = 1'b0;
            if (ascii != 8'h00 && ascii != m_prev) begin
                ev      = 1'b1;
                m_press = m_cyc;
            end else if (ascii != 8'h00) begin
                age = m_cyc - m_press;
`ifdef KB_SCHED_REPEAT_EN
                if (age == c_DELAY || (age > c_DELAY && (age - c_DELAY) % c_PERIOD == 0)) begin
                    ev  = 1'b1;
                    rep = 1'b1;
                end
`endif
            end
            m_prev  = ascii;
            irq_nxt = bus.irq_en && (m_q.size() != 0);
            pop     = bus.rd_en && (m_q.size() != 0);
            if (ev && !pop && m_q.size() == c_DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                if (bus.clr_ovf) m_ovf = 1'b0;
                if (pop) void'(m_q.pop_front());
                if (ev) m_q.push_back({2'b00, rep, mods, ascii});
            end
            if (pop && ev && m_q.size() > c_DEPTH) m_q.delete(m_q.size() - 1);
            m_irq = irq_nxt;
        end
    end

    always @(negedge CLOCK_50) begin
        if (m_live) begin
            check("count",    32'(bus.count),    32'(m_q.size()));
            check("empty",    32'(bus.empty),    32'(m_q.size() == 0));
            check("rd_data",  32'(bus.rd_data),  (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("irq",      32'(bus.irq),      32'(m_irq));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pop_expect(input string name, input logic [15:0] exp);
        check(name, 32'(bus.rd_data), 32'(exp));
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        ascii       = 8'h00;
        mods        = 5'b00000;
        bus.rd_en   = 1'b0;
        bus.irq_en  = 1'b1;
        bus.clr_ovf = 1'b0;
        tick(2);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_data",  32'(bus.rd_data), 32'h0);
        rst = 1'b0;

        // Short press of 'a' with shift
        ascii = 8'h61; mods = 5'b00001;
        tick(1);
        check("t1_count", 32'(bus.count), 32'd1);
        check("t1_irq_lag", 32'(bus.irq), 32'd0);
        tick(1);
        check("t1_irq", 32'(bus.irq), 32'd1);
        tick(1);
        ascii = 8'h00; mods = 5'b00000;
        tick(1);
        check("t1_data", 32'(bus.rd_data), 32'h0161);
        check("t1_count2", 32'(bus.count), 32'd1);
        pop_expect("t1_pop", 16'h0161);
        tick(1);
        check("t1_irq_off", 32'(bus.irq), 32'd0);

        // Pop on empty is ignored
        bus.rd_en = 1'b1;
        tick(2);
        bus.rd_en = 1'b0;
        check("t5_count", 32'(bus.count), 32'd0);
        check("t5_data",  32'(bus.rd_data), 32'h0);
        check("t5_irq",   32'(bus.irq), 32'd0);

        // Long hold of 'A': edges 0..30
        ascii = 8'h41;
        tick(31);
        ascii = 8'h00;
        tick(1);
`ifdef KB_SCHED_REPEAT_EN
        check("t2_count", 32'(bus.count), 32'd4);
        check("t2_ovf",   32'(bus.overflow), 32'd1);
        pop_expect("t2_pop0", 16'h0041);
        pop_expect("t2_pop1", 16'h2041);
        pop_expect("t2_pop2", 16'h2041);
        pop_expect("t2_pop3", 16'h2041);
`else
        check("t2_count", 32'(bus.count), 32'd1);
        check("t2_ovf",   32'(bus.overflow), 32'd0);
        pop_expect("t2_pop0", 16'h0041);
`endif
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        check("t5_clr_ovf", 32'(bus.overflow), 32'd0);

        // Key change while repeating
        ascii = 8'h61;
        tick(13);
        ascii = 8'h62;
        tick(1);
`ifdef KB_SCHED_REPEAT_EN
        check("t3_press", 32'(bus.count), 32'd3);
        tick(9);
        check("t3_no_rep", 32'(bus.count), 32'd3);
        tick(1);
        check("t3_rep", 32'(bus.count), 32'd4);
`else
        check("t3_press", 32'(bus.count), 32'd2);
        tick(10);
        check("t3_rep", 32'(bus.count), 32'd2);
`endif

        // Push coinciding with pop
        ascii = 8'h63;
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        ascii = 8'h00;
`ifdef KB_SCHED_REPEAT_EN
        check("t4_count", 32'(bus.count), 32'd4);
        check("t4_ovf",   32'(bus.overflow), 32'd0);
        check("t4_head",  32'(bus.rd_data), 32'h2061);
`else
        check("t4_count", 32'(bus.count), 32'd2);
        check("t4_head",  32'(bus.rd_data), 32'h0062);
`endif
        bus.rd_en = 1'b1;
        tick(5);
        bus.rd_en = 1'b0;
        check("drain", 32'(bus.count), 32'd0);

        // Reset in the middle of a hold with two entries queued
        ascii = 8'h64; tick(1);
        ascii = 8'h00; tick(1);
        ascii = 8'h65; tick(3);
        check("t6_pre", 32'(bus.count), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_count", 32'(bus.count), 32'd0);
        check("t6_empty", 32'(bus.empty), 32'd1);
        check("t6_irq",   32'(bus.irq), 32'd0);
        tick(1);
        check("t6_press", 32'(bus.rd_data), 32'h0065);
        bus.irq_en = 1'b0;
        tick(2);
        check("t6_irq_dis", 32'(bus.irq), 32'd0);
        bus.irq_en = 1'b1;
        ascii = 8'h00;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
